// File: rtl/issue_ctrl_pkg.sv
// Shared constants for the dispatch-stage issue scheduler: structure sizes,
// counter width helper and FSM state encodings.
package issue_ctrl_pkg;

    localparam int ROB_SIZE_DEF = 16;
    localparam int RS_SIZE_DEF  = 16;
    localparam int LSB_SIZE_DEF = 16;

    typedef enum logic {
        ISSUE_RUN   = 1'b0,
        ISSUE_FLUSH = 1'b1
    } issue_state_e;

    // Width of a credit counter that must hold every value 0..size
    function automatic int cnt_w(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/issue_ctrl_credit_counter.sv
// Free-slot credit counter for one back-end structure; reports the value it
// will hold after this edge so the stall logic can look one cycle ahead.
module credit_counter
    import issue_ctrl_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     take,
    input  logic                     give,
    input  logic                     reload,
    input  logic [cnt_w(SIZE)-1:0]   reload_val,
    output logic [cnt_w(SIZE)-1:0]   free,
    output logic [cnt_w(SIZE)-1:0]   free_nxt,
    output logic                     ovf
);

    localparam int CW = cnt_w(SIZE);

    logic [CW-1:0] free_q;
    logic [CW-1:0] free_d;
    logic          ovf_d;

    always_comb begin
        free_d = free_q;
        ovf_d  = 1'b0;
        if (reload) begin
            free_d = reload_val;
        end else if (take && !give) begin
            free_d = free_q - 1'b1;
        end else if (give && !take) begin
            // A release with every slot already free is a bookkeeping error upstream
            if (free_q == CW'(SIZE)) begin
                ovf_d = 1'b1;
            end else begin
                free_d = free_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_q <= CW'(SIZE);
        end else if (en) begin
            free_q <= free_d;
        end
    end

    assign free     = free_q;
    assign free_nxt = en ? free_d : free_q;
    assign ovf      = en & ovf_d;

endmodule

// File: rtl/issue_ctrl.sv
// Credit-based issue scheduler: grants one dispatch per cycle when ROB and the
// target RS/LSB have room, back-pressures fetch, and recovers credits on flush.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int ROB_SIZE     = ROB_SIZE_DEF,
    parameter int RS_SIZE      = RS_SIZE_DEF,
    parameter int LSB_SIZE     = LSB_SIZE_DEF,
    parameter int STALL_MARGIN = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         issue_valid,
    input  logic                         issue_is_nop,
    input  logic                         issue_is_ls,
    input  logic                         rob_commit,
    input  logic                         rs_release,
    input  logic                         lsb_release,
    input  logic                         misbranch_flag,
    input  logic [cnt_w(LSB_SIZE)-1:0]   lsb_kept,
    output logic                         issue_grant,
    output logic                         stall_to_if,
    output logic                         flushing,
    output logic [cnt_w(ROB_SIZE)-1:0]   rob_free,
    output logic [cnt_w(RS_SIZE)-1:0]    rs_free,
    output logic [cnt_w(LSB_SIZE)-1:0]   lsb_free,
    output logic                         ovf_err
);

    localparam int RBW = cnt_w(ROB_SIZE);
    localparam int RSW = cnt_w(RS_SIZE);
    localparam int LBW = cnt_w(LSB_SIZE);
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    issue_state_e   state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           stall_q, stall_d;
    logic           ovf_q, ovf_d;

    logic           run, reload;
    logic [RBW-1:0] rob_nxt;
    logic [RSW-1:0] rs_nxt;
    logic [LBW-1:0] lsb_nxt, lsb_reload;
    logic           rob_ovf, rs_ovf, lsb_ovf;

    assign run    = (state_q == ISSUE_RUN);
    assign reload = rdy & misbranch_flag;

    // Stores kept past the flush still occupy LSB slots; clamp bogus counts to empty
    assign lsb_reload = (lsb_kept > LBW'(LSB_SIZE)) ? '0 : LBW'(LSB_SIZE) - lsb_kept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ISSUE_RUN;
            fcnt_q  <= '0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            stall_q <= stall_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (rdy) begin
            if (misbranch_flag) begin
                state_d = ISSUE_FLUSH;
                fcnt_d  = FCW'(FLUSH_CYCLES - 1);
            end else if (state_q == ISSUE_FLUSH) begin
                if (fcnt_q == '0) begin
                    state_d = ISSUE_RUN;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        issue_grant = rdy & run & issue_valid & !issue_is_nop & !misbranch_flag
                    & (rob_free != '0)
                    & (issue_is_ls ? (lsb_free != '0) : (rs_free != '0));
        flushing    = (state_q == ISSUE_FLUSH);
        stall_d     = stall_q;
        if (rdy) begin
            stall_d = (32'(rob_nxt) <= STALL_MARGIN) | (32'(rs_nxt) <= STALL_MARGIN)
                    | (32'(lsb_nxt) <= STALL_MARGIN) | (state_d == ISSUE_FLUSH);
        end
        ovf_d = ovf_q | rob_ovf | rs_ovf | lsb_ovf;
    end

    credit_counter #(.SIZE(ROB_SIZE)) u_rob (
        .clk(clk), .rst(rst), .en(rdy),
        .take(issue_grant), .give(rob_commit & run & !misbranch_flag),
        .reload(reload), .reload_val(RBW'(ROB_SIZE)),
        .free(rob_free), .free_nxt(rob_nxt), .ovf(rob_ovf)
    );

    credit_counter #(.SIZE(RS_SIZE)) u_rs (
        .clk(clk), .rst(rst), .en(rdy),
        .take(issue_grant & !issue_is_ls), .give(rs_release & run & !misbranch_flag),
        .reload(reload), .reload_val(RSW'(RS_SIZE)),
        .free(rs_free), .free_nxt(rs_nxt), .ovf(rs_ovf)
    );

    // LSB drains keep returning credits during FLUSH
    credit_counter #(.SIZE(LSB_SIZE)) u_lsb (
        .clk(clk), .rst(rst), .en(rdy),
        .take(issue_grant & issue_is_ls), .give(lsb_release & !misbranch_flag),
        .reload(reload), .reload_val(lsb_reload),
        .free(lsb_free), .free_nxt(lsb_nxt), .ovf(lsb_ovf)
    );

    assign stall_to_if = stall_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl with default parameters.
module tb_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst, rdy, issue_valid, issue_is_nop, issue_is_ls;
    logic       rob_commit, rs_release, lsb_release, misbranch_flag;
    logic [4:0] lsb_kept;
    logic       issue_grant, stall_to_if, flushing, ovf_err;
    logic [4:0] rob_free, rs_free, lsb_free;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    issue_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_is_nop(issue_is_nop), .issue_is_ls(issue_is_ls),
        .rob_commit(rob_commit), .rs_release(rs_release), .lsb_release(lsb_release),
        .misbranch_flag(misbranch_flag), .lsb_kept(lsb_kept),
        .issue_grant(issue_grant), .stall_to_if(stall_to_if), .flushing(flushing),
        .rob_free(rob_free), .rs_free(rs_free), .lsb_free(lsb_free), .ovf_err(ovf_err)
    );

    task automatic idle();
        rdy = 1'b1; issue_valid = 1'b0; issue_is_nop = 1'b0; issue_is_ls = 1'b0;
        rob_commit = 1'b0; rs_release = 1'b0; lsb_release = 1'b0;
        misbranch_flag = 1'b0; lsb_kept = '0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (rob_free !== 5'd16) begin n_fail++; $display("FAIL reset_rob got %0d want 16", rob_free); end
        n_checks++; if (rs_free !== 5'd16) begin n_fail++; $display("FAIL reset_rs got %0d want 16", rs_free); end
        n_checks++; if (lsb_free !== 5'd16) begin n_fail++; $display("FAIL reset_lsb got %0d want 16", lsb_free); end
        n_checks++; if (stall_to_if !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_to_if); end
        n_checks++; if (flushing !== 1'b0) begin n_fail++; $display("FAIL reset_flushing got %b want 0", flushing); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf_err); end
    endtask

    // Fill the RS, then recover one slot while a new RS op waits
    task automatic test_rs_fill();
        do_reset();
        issue_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            n_checks++; if (issue_grant !== 1'b1) begin n_fail++; $display("FAIL fill_grant%0d got %b want 1", i, issue_grant); end
            tick();
            n_checks++; if (rs_free !== 5'(16 - i)) begin n_fail++; $display("FAIL fill_rs%0d got %0d want %0d", i, rs_free, 16 - i); end
            n_checks++; if (stall_to_if !== ((16 - i) <= 2)) begin n_fail++; $display("FAIL fill_stall%0d got %b want %b", i, stall_to_if, (16 - i) <= 2); end
        end
        #1;
        n_checks++; if (issue_grant !== 1'b0) begin n_fail++; $display("FAIL fill_grant17 got %b want 0", issue_grant); end
        tick();
        issue_valid = 1'b0;
        rob_commit  = 1'b1;
        repeat (5) tick();
        rob_commit = 1'b0;
        n_checks++; if (rob_free !== 5'd5) begin n_fail++; $display("FAIL commit_rob got %0d want 5", rob_free); end
        n_checks++; if (rs_free !== 5'd0) begin n_fail++; $display("FAIL commit_rs got %0d want 0", rs_free); end
        rs_release  = 1'b1;
        issue_valid = 1'b1;
        #1;
        n_checks++; if (issue_grant !== 1'b0) begin n_fail++; $display("FAIL rel_cycle_grant got %b want 0", issue_grant); end
        tick();
        rs_release = 1'b0;
        n_checks++; if (rs_free !== 5'd1) begin n_fail++; $display("FAIL rel_rs got %0d want 1", rs_free); end
        #1;
        n_checks++; if (issue_grant !== 1'b1) begin n_fail++; $display("FAIL after_rel_grant got %b want 1", issue_grant); end
        tick();
        issue_valid = 1'b0;
        n_checks++; if (rs_free !== 5'd0) begin n_fail++; $display("FAIL after_rel_rs got %0d want 0", rs_free); end
        n_checks++; if (rob_free !== 5'd4) begin n_fail++; $display("FAIL after_rel_rob got %0d want 4", rob_free); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue_valid = 1'b1;
        repeat (13) tick();
        n_checks++; if (rs_free !== 5'd3) begin n_fail++; $display("FAIL b2b_pre_rs got %0d want 3", rs_free); end
        rs_release = 1'b1;
        #1;
        n_checks++; if (issue_grant !== 1'b1) begin n_fail++; $display("FAIL b2b_grant got %b want 1", issue_grant); end
        tick();
        rs_release  = 1'b0;
        issue_valid = 1'b0;
        n_checks++; if (rs_free !== 5'd3) begin n_fail++; $display("FAIL b2b_rs got %0d want 3", rs_free); end
        n_checks++; if (rob_free !== 5'd2) begin n_fail++; $display("FAIL b2b_rob got %0d want 2", rob_free); end
        n_checks++; if (stall_to_if !== 1'b1) begin n_fail++; $display("FAIL b2b_stall got %b want 1", stall_to_if); end
    endtask

    // Relies on the state left by test_back_to_back: rob 2, rs 3, lsb 16
    task automatic test_nop_rdy();
        issue_valid  = 1'b1;
        issue_is_nop = 1'b1;
        #1;
        n_checks++; if (issue_grant !== 1'b0) begin n_fail++; $display("FAIL nop_grant got %b want 0", issue_grant); end
        tick();
        issue_is_nop = 1'b0;
        n_checks++; if (rob_free !== 5'd2) begin n_fail++; $display("FAIL nop_rob got %0d want 2", rob_free); end
        n_checks++; if (rs_free !== 5'd3) begin n_fail++; $display("FAIL nop_rs got %0d want 3", rs_free); end
        rdy = 1'b0; rob_commit = 1'b1; rs_release = 1'b1; lsb_release = 1'b1; misbranch_flag = 1'b1;
        #1;
        n_checks++; if (issue_grant !== 1'b0) begin n_fail++; $display("FAIL rdy0_grant got %b want 0", issue_grant); end
        tick();
        tick();
        n_checks++; if (rob_free !== 5'd2) begin n_fail++; $display("FAIL rdy0_rob got %0d want 2", rob_free); end
        n_checks++; if (rs_free !== 5'd3) begin n_fail++; $display("FAIL rdy0_rs got %0d want 3", rs_free); end
        n_checks++; if (lsb_free !== 5'd16) begin n_fail++; $display("FAIL rdy0_lsb got %0d want 16", lsb_free); end
        n_checks++; if (flushing !== 1'b0) begin n_fail++; $display("FAIL rdy0_flushing got %b want 0", flushing); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL rdy0_ovf got %b want 0", ovf_err); end
        n_checks++; if (stall_to_if !== 1'b1) begin n_fail++; $display("FAIL rdy0_stall got %b want 1", stall_to_if); end
        idle();
    endtask

    task automatic test_flush();
        issue_valid    = 1'b1;
        issue_is_ls    = 1'b1;
        misbranch_flag = 1'b1;
        lsb_kept       = 5'd3;
        #1;
        n_checks++; if (issue_grant !== 1'b0) begin n_fail++; $display("FAIL mis_grant got %b want 0", issue_grant); end
        tick();
        misbranch_flag = 1'b0;
        n_checks++; if (flushing !== 1'b1) begin n_fail++; $display("FAIL flush1 got %b want 1", flushing); end
        n_checks++; if (rob_free !== 5'd16) begin n_fail++; $display("FAIL flush_rob got %0d want 16", rob_free); end
        n_checks++; if (rs_free !== 5'd16) begin n_fail++; $display("FAIL flush_rs got %0d want 16", rs_free); end
        n_checks++; if (lsb_free !== 5'd13) begin n_fail++; $display("FAIL flush_lsb got %0d want 13", lsb_free); end
        n_checks++; if (stall_to_if !== 1'b1) begin n_fail++; $display("FAIL flush_stall got %b want 1", stall_to_if); end
        rob_commit = 1'b1; rs_release = 1'b1; lsb_release = 1'b1;
        #1;
        n_checks++; if (issue_grant !== 1'b0) begin n_fail++; $display("FAIL flush1_grant got %b want 0", issue_grant); end
        tick();
        rob_commit = 1'b0; rs_release = 1'b0; lsb_release = 1'b0;
        n_checks++; if (flushing !== 1'b1) begin n_fail++; $display("FAIL flush2 got %b want 1", flushing); end
        n_checks++; if (lsb_free !== 5'd14) begin n_fail++; $display("FAIL flush_lsbrel got %0d want 14", lsb_free); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL flush_ignored_ovf got %b want 0", ovf_err); end
        #1;
        n_checks++; if (issue_grant !== 1'b0) begin n_fail++; $display("FAIL flush2_grant got %b want 0", issue_grant); end
        tick();
        n_checks++; if (flushing !== 1'b0) begin n_fail++; $display("FAIL flush_exit got %b want 0", flushing); end
        n_checks++; if (stall_to_if !== 1'b0) begin n_fail++; $display("FAIL flush_exit_stall got %b want 0", stall_to_if); end
        #1;
        n_checks++; if (issue_grant !== 1'b1) begin n_fail++; $display("FAIL post_flush_grant got %b want 1", issue_grant); end
        tick();
        idle();
        n_checks++; if (lsb_free !== 5'd13) begin n_fail++; $display("FAIL post_flush_lsb got %0d want 13", lsb_free); end
        n_checks++; if (rob_free !== 5'd15) begin n_fail++; $display("FAIL post_flush_rob got %0d want 15", rob_free); end
    endtask

    task automatic test_ovf();
        do_reset();
        lsb_release = 1'b1;
        tick();
        lsb_release = 1'b0;
        n_checks++; if (lsb_free !== 5'd16) begin n_fail++; $display("FAIL ovf_lsb got %0d want 16", lsb_free); end
        n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", ovf_err); end
        tick();
        tick();
        n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf_err); end
        do_reset();
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", ovf_err); end
    endtask

    task automatic test_reset_mid_flush();
        issue_valid = 1'b1;
        repeat (3) tick();
        misbranch_flag = 1'b1;
        lsb_kept       = 5'd7;
        tick();
        idle();
        n_checks++; if (flushing !== 1'b1) begin n_fail++; $display("FAIL mid_flush got %b want 1", flushing); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (flushing !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flushing got %b want 0", flushing); end
        n_checks++; if (lsb_free !== 5'd16) begin n_fail++; $display("FAIL mid_rst_lsb got %0d want 16", lsb_free); end
        n_checks++; if (stall_to_if !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stall got %b want 0", stall_to_if); end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_rs_fill();
        test_back_to_back();
        test_nop_rdy();
        test_flush();
        test_ovf();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
